// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - clock divider ratio monitor: edge sync, period measure, lock and fault
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 4
) (
  input  logic        clk32M768,
  input  logic        rst_n,
  input  logic        clk_in,
  input  logic [3:0]  sel,
  input  logic        fault_clr,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic [16:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        fault
);

  typedef enum logic {IDLE, MEAS} state_e;

  localparam logic signed [17:0] TOL_S  = 18'(TOL);
  localparam logic [3:0]         LOCK_V = 4'(LOCK_CNT);

  logic [1:0]             rst_sync_q;
  logic                   rst_ok;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [3:0]             sel_c, sel_q, sel_d;
  logic                   sel_chg;
  state_e                 state_q, state_d;
  logic [16:0]            cnt_q, cnt_d;
  logic [16:0]            period_q, period_d;
  logic [16:0]            exp_w, tmo_m1;
  logic                   pv_q, pv_d;
  logic [3:0]             good_q, good_d;
  logic                   locked_q, locked_d;
  logic                   fault_q, fault_d, fault_set;
  logic signed [17:0]     diff;
  logic                   in_tol;

  // Assertion is immediate; release reaches the rest of the logic two edges later.
  always_ff @(posedge clk32M768 or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ok = rst_sync_q[1];

  assign sel_c   = (sel > 4'd14) ? 4'd14 : sel;
  assign sel_chg = (sel_c != sel_q);
  assign exp_w   = 17'd1 << (sel_q + 4'd1);
  assign tmo_m1  = (exp_w << 1) - 17'd1;
  assign diff    = $signed({1'b0, cnt_q}) + 18'sd1 - $signed({1'b0, exp_w});
  assign in_tol  = (diff <= TOL_S) && (diff >= -TOL_S);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], clk_in};
    hist_d    = sync_q[SYNC_STAGES-1];
    rise_d    = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d    = ~sync_q[SYNC_STAGES-1] & hist_q;
    sel_d     = sel_c;
    state_d   = state_q;
    cnt_d     = cnt_q + 17'd1;
    period_d  = period_q;
    pv_d      = 1'b0;
    good_d    = good_q;
    fault_set = 1'b0;

    // Ratio change outranks an edge arriving in the same cycle.
    if (sel_chg) begin
      state_d = IDLE;
      cnt_d   = '0;
      good_d  = '0;
    end else if (rise_q) begin
      state_d = MEAS;
      cnt_d   = '0;
      if (state_q == MEAS) begin
        period_d = cnt_q + 17'd1;
        pv_d     = 1'b1;
        if (in_tol) begin
          if (good_q != LOCK_V) good_d = good_q + 4'd1;
        end else begin
          good_d    = '0;
          fault_set = 1'b1;
        end
      end
    end else if (cnt_q >= tmo_m1) begin
      state_d   = IDLE;
      cnt_d     = '0;
      good_d    = '0;
      fault_set = 1'b1;
    end

    fault_d = fault_q;
    if (fault_clr) fault_d = 1'b0;
    if (fault_set) fault_d = 1'b1;
    locked_d = (good_d == LOCK_V);

    if (!rst_ok) begin
      sync_d   = '0;
      hist_d   = 1'b0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      sel_d    = '0;
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      pv_d     = 1'b0;
      good_d   = '0;
      locked_d = 1'b0;
      fault_d  = 1'b0;
    end
  end

  always_ff @(posedge clk32M768 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sel_q    <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      good_q   <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sel_q    <= sel_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed table and sequence bench for clk_div_monitor
module tb_clk_div_monitor;

  logic        clk32M768 = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clk_in    = 1'b0;
  logic [3:0]  sel       = 4'd0;
  logic        fault_clr = 1'b0;
  logic        rise_pulse, fall_pulse, period_valid, locked, fault;
  logic [16:0] period;

  int checks = 0, errors = 0;
  int cyc = 0, n_rise = 0, n_pv = 0, lock_rise = 0, per_err = 0;
  int exp_period = 16;
  logic [16:0] last_period = '0;
  bit gen_en = 0;
  int div = 16, ph = 0, cur_len = 16, stretch_len = 0;

  typedef struct {
    logic [3:0] sel;
    int         div;
    int         exp_per;
    bit         exp_lock;
    bit         exp_fault;
  } vec_t;
  vec_t vecs[8];

  clk_div_monitor #(.SYNC_STAGES(2), .TOL(1), .LOCK_CNT(4)) dut (
    .clk32M768   (clk32M768),
    .rst_n       (rst_n),
    .clk_in      (clk_in),
    .sel         (sel),
    .fault_clr   (fault_clr),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .fault       (fault)
  );

  always #5 clk32M768 = ~clk32M768;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
    end
  endtask

  task automatic clr_stats();
    n_rise = 0; n_pv = 0; lock_rise = 0; per_err = 0;
  endtask

  // One clock: sample outputs 1ns after the edge, then advance the clk_in pattern.
  task automatic cycle();
    @(posedge clk32M768);
    #1;
    cyc++;
    if (rise_pulse) n_rise++;
    if (period_valid) begin
      n_pv++;
      last_period = period;
      if (period != 17'(exp_period)) per_err++;
    end
    if (locked && lock_rise == 0) lock_rise = n_rise;
    if (gen_en) begin
      if (ph == 0) begin
        cur_len     = (stretch_len != 0) ? stretch_len : div;
        stretch_len = 0;
      end
      clk_in = (ph < cur_len / 2);
      ph++;
      if (ph >= cur_len) ph = 0;
    end
  endtask

  task automatic apply_reset(input logic [3:0] s);
    rst_n = 1'b0; fault_clr = 1'b0; sel = s;
    gen_en = 0; clk_in = 1'b0; ph = 0; stretch_len = 0;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    clr_stats();
  endtask

  task automatic wait_rise(input string nm);
    int g;
    g = 0;
    cycle();
    while (!rise_pulse && g < 80) begin
      cycle();
      g++;
    end
    check({nm, " rise seen"}, rise_pulse, 1);
  endtask

  task automatic acquire_lock(input string nm);
    int g;
    g = 0;
    clr_stats();
    while (!locked && g < 600) begin
      cycle();
      g++;
      fault_clr = rise_pulse && (n_rise == 1);
    end
    fault_clr = 1'b0;
    check({nm, " lock rise"}, lock_rise, 5);
    check({nm, " pv count"}, n_pv, 4);
    check({nm, " period err"}, per_err, 0);
    check({nm, " fault"}, fault, 0);
  endtask

  initial begin
    int t_r, t_f, g;
    bit found;

    vecs[0] = '{4'd0,  2,  2, 1'b1, 1'b0};
    vecs[1] = '{4'd1,  4,  4, 1'b1, 1'b0};
    vecs[2] = '{4'd2,  8,  8, 1'b1, 1'b0};
    vecs[3] = '{4'd3, 16, 16, 1'b1, 1'b0};
    vecs[4] = '{4'd4, 32, 32, 1'b1, 1'b0};
    vecs[5] = '{4'd3, 17, 17, 1'b1, 1'b0};
    vecs[6] = '{4'd3, 15, 15, 1'b1, 1'b0};
    vecs[7] = '{4'd3, 18, 18, 1'b0, 1'b1};

    // Reset values and edge-detect latency
    sel = 4'd3;
    repeat (2) cycle();
    check("rst rise_pulse", rise_pulse, 0);
    check("rst fall_pulse", fall_pulse, 0);
    check("rst period", period, 0);
    check("rst period_valid", period_valid, 0);
    check("rst locked", locked, 0);
    check("rst fault", fault, 0);
    rst_n = 1'b1;
    repeat (4) cycle();
    clk_in = 1'b1;
    repeat (2) cycle();
    check("rise early", rise_pulse, 0);
    cycle();
    check("rise latency", rise_pulse, 1);
    cycle();
    check("rise one-shot", rise_pulse, 0);
    clk_in = 1'b0;
    repeat (2) cycle();
    check("fall early", fall_pulse, 0);
    cycle();
    check("fall latency", fall_pulse, 1);

    // Steady ratios, in and out of tolerance
    for (int i = 0; i < 8; i++) begin
      apply_reset(vecs[i].sel);
      div = vecs[i].div; exp_period = vecs[i].exp_per; gen_en = 1;
      g = 0;
      while (n_rise < 8 && g < 2000) begin
        cycle();
        g++;
        fault_clr = rise_pulse && (n_rise == 1);
      end
      fault_clr = 1'b0;
      cycle();
      check($sformatf("vec%0d rises", i), n_rise, 8);
      check($sformatf("vec%0d period", i), last_period, vecs[i].exp_per);
      check($sformatf("vec%0d period err", i), per_err, 0);
      check($sformatf("vec%0d pv count", i), n_pv, n_rise - 1);
      check($sformatf("vec%0d locked", i), locked, vecs[i].exp_lock);
      check($sformatf("vec%0d fault", i), fault, vecs[i].exp_fault);
      if (vecs[i].exp_lock) check($sformatf("vec%0d lock rise", i), lock_rise, 5);
    end

    // Stuck-low timeout at exp=32, with fault_clr colliding on the timeout edge
    apply_reset(4'd4);
    exp_period = 32;
    clk_in = 1'b1;
    wait_rise("tmo");
    t_r = cyc;
    clk_in = 1'b0;
    check("tmo pre fault", fault, 0);
    t_f = 0;
    for (int k = 0; k < 100 && t_f == 0; k++) begin
      cycle();
      if (fault) t_f = cyc;
      fault_clr = (cyc == t_r + 64);
    end
    fault_clr = 1'b0;
    check("tmo cycle", t_f - t_r, 65);
    check("tmo locked", locked, 0);
    check("tmo no pv", n_pv, 0);
    clk_in = 1'b1;
    wait_rise("tmo idle");
    cycle();
    check("tmo idle rise pv", period_valid, 0);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    check("tmo clear", fault, 0);

    // Lock, stretched period, relock, clear
    apply_reset(4'd3);
    div = 16; exp_period = 16; gen_en = 1;
    acquire_lock("s3");
    stretch_len = 19;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      cycle();
      if (period_valid && period == 17'd19) found = 1;
    end
    check("stretch seen", found, 1);
    check("stretch fault", fault, 1);
    check("stretch locked", locked, 0);
    n_pv = 0; per_err = 0;
    g = 0;
    while (!locked && g < 300) begin
      cycle();
      g++;
    end
    check("relock pv count", n_pv, 4);
    check("relock period err", per_err, 0);
    check("relock fault sticky", fault, 1);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    check("fault_clr", fault, 0);

    // Reset mid-period while locked
    wait_rise("rst mid");
    repeat (5) cycle();
    rst_n = 1'b0;
    #1;
    check("rst async zero", {rise_pulse, fall_pulse, period_valid, locked, fault, period}, 0);
    repeat (3) cycle();
    check("rst hold zero", {rise_pulse, fall_pulse, period_valid, locked, fault, period}, 0);
    rst_n = 1'b1;
    acquire_lock("rst relock");

    // Ratio switch 3 -> 4 while locked, on a rise cycle
    wait_rise("sel sw");
    sel = 4'd4; div = 32; exp_period = 32;
    cycle();
    check("sel sw locked", locked, 0);
    check("sel sw fault", fault, 0);
    check("sel sw prio pv", period_valid, 0);
    acquire_lock("s4");
    check("s4 period", last_period, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth for clk_in (legal 2..4).
REQ-002 Parameter TOL, default 1: allowed period error in clk32M768 cycles.
REQ-003 Parameter LOCK_CNT, default 4: consecutive good periods required to lock (legal 1..15).
REQ-004 clk32M768  in  1  system clock, 32.768 MHz.
REQ-005 rst_n  in  1  reset; one clock; reset asynchronous, active-low.
REQ-006 clk_in  in  1  divided clock under test; may be asynchronous to clk32M768.
REQ-007 sel  in  4  expected ratio: exp = 2^(sel+1) clk32M768 cycles per clk_in period; sel>14 treated as 14.
REQ-008 fault_clr  in  1  single-cycle pulse; clears sticky fault.
REQ-009 rise_pulse  out  1  one-cycle strobe per synchronised clk_in rising edge.
REQ-010 fall_pulse  out  1  one-cycle strobe per synchronised clk_in falling edge.
REQ-011 period  out  17  last measured rise-to-rise period in clk32M768 cycles.
REQ-012 period_valid  out  1  one-cycle strobe when period updates.
REQ-013 locked  out  1  LOCK_CNT consecutive in-tolerance periods seen.
REQ-014 fault  out  1  sticky: out-of-tolerance period or stuck clock detected.

Function
REQ-015 clk_in SHALL pass through a SYNC_STAGES flop chain plus one history flop; rise/fall = last stage vs history.
REQ-016 rise_pulse SHALL assert exactly SYNC_STAGES+1 clk32M768 edges after the first edge sampling clk_in high; same latency for fall_pulse.
REQ-017 A 17-bit counter cnt SHALL increment every cycle and load 0 on rise_pulse, on sel change and on timeout.
REQ-018 FSM states: IDLE (awaiting first rise), MEAS (measuring); reset state IDLE.
REQ-019 IDLE: on rise_pulse -> MEAS, cnt<=0, no period_valid.
REQ-020 MEAS: on rise_pulse, period<=cnt+1 and period_valid=1 in the same edge; remain MEAS.
REQ-021 Good period: |(cnt+1) - exp| <= TOL, computed at 18-bit signed width, no wrap.
REQ-022 Good period: good_cnt increments, saturating at LOCK_CNT; bad period: good_cnt<=0, fault<=1.
REQ-023 locked SHALL equal (good_cnt==LOCK_CNT), registered; it drops the cycle after a bad period, timeout or sel change.
REQ-024 Timeout: in IDLE or MEAS, cnt reaching 2*exp (17-bit, 65536 at sel=14) without rise -> fault<=1, good_cnt<=0, state IDLE, cnt<=0.
REQ-025 sel change (sel registered, compared with previous) -> state IDLE, good_cnt<=0, cnt<=0; fault unaffected; takes priority over rise_pulse in that cycle.
REQ-026 fault_clr SHALL clear fault unless a new fault event occurs in the same cycle, where set wins.
REQ-027 Back-to-back rises (clk_in at exp=2) SHALL be measured every second cycle without loss.

Reset
REQ-028 While rst_n=0: state IDLE, cnt=0, period=0, period_valid=0, rise_pulse=0, fall_pulse=0, good_cnt=0, locked=0, fault=0, sync flops=0.
REQ-029 Reset assertion mid-period SHALL abort measurement; first rise after release is treated as IDLE rise (no period_valid).
REQ-030 Deassertion SHALL be synchronised internally before FSM use; outputs glitch-free.

Verification
REQ-031 sel=3, clk_in = clk32M768/16 -> period=16 on each period_valid; locked=1 after 5th rise (4 good periods); fault=0.
REQ-032 sel=0, clk_in = clk32M768/2 synchronous -> period=2 every second cycle, locked after 5 rises, no missed period_valid.
REQ-033 sel=3, locked, one period stretched to 19 -> fault=1, locked=0 next cycle; relock after 4 further good periods; fault_clr -> fault=0.
REQ-034 sel=4 (exp=32), clk_in held low -> fault=1 exactly when cnt reaches 64; state IDLE; locked=0.
REQ-035 locked at sel=3, switch sel to 4 with clk_in /32 -> locked=0, fault=0, first rise gives no period_valid, locked after 4 further good periods.
REQ-036 rst_n pulsed low mid-period while locked -> all outputs 0 immediately; after release, lock re-acquired per REQ-031.
